// File: rtl/regfile_arb_pkg.sv
// rtl/regfile_arb_pkg.sv - shared constants and FSM state type for the regfile write arbiter
package regfile_arb_pkg;

    localparam int ADDR_W      = 5;
    localparam int NUM_REGS    = 32;
    // Clear sweep covers r1..r31; r0 is hard-wired zero in the regfile and never addressed.
    localparam int CLEAR_FIRST = 1;
    localparam int CLEAR_LAST  = 31;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        DONE  = 2'd2
    } arb_state_e;

endpackage

// File: rtl/regfile_write_arbiter_rr_arbiter.sv
// rtl/regfile_write_arbiter_rr_arbiter.sv - combinational round-robin priority picker
//   req        in   NUM_REQ  candidate requests
//   ptr        in   PTR_W    index with highest priority this cycle
//   grant      out  NUM_REQ  one-hot winner (zero when no request)
//   grant_idx  out  PTR_W    encoded winner index
//   grant_any  out  1        some request won
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [PTR_W-1:0]   grant_idx,
    output logic               grant_any
);

    int            scan;
    logic [PTR_W-1:0] scan_idx;

    // Walk indices ptr, ptr+1, ... modulo NUM_REQ; the first valid one wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        scan      = 0;
        scan_idx  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan     = (int'(ptr) + k) % NUM_REQ;
            scan_idx = PTR_W'(scan);
            if (!grant_any && req[scan_idx]) begin
                grant_any         = 1'b1;
                grant[scan_idx]   = 1'b1;
                grant_idx         = scan_idx;
            end
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// rtl/regfile_write_arbiter.sv - round-robin sharing of the regfile write port plus r1..r31 clear sequencer
//   clock, ctrl_reset  rising-edge clock, synchronous active-high reset
//   req_valid/addr/data  per-requester write requests (flattened, slice i = requester i)
//   req_ready           one-hot combinational grant
//   clear_req           pulse to start zeroing r1..r31
//   clear_busy          sweep in progress; clear_done one-cycle pulse after the last write
//   wr_en/wr_addr/wr_data  registered regfile write port
//   Optional build macro REGFILE_ARB_R0_DROP_EN: granted writes to r0 are acknowledged but not issued.
module regfile_write_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5
) (
    input  logic                       clock,
    input  logic                       ctrl_reset,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0]  req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]  req_data,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic                       clear_req,
    output logic                       clear_busy,
    output logic                       clear_done,
    output logic                       wr_en,
    output logic [ADDR_W-1:0]          wr_addr,
    output logic [DATA_W-1:0]          wr_data
);

    import regfile_arb_pkg::*;

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    arb_state_e        state_q, state_d;
    logic [PTR_W-1:0]  ptr_q, ptr_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;

    logic [NUM_REQ-1:0] grant;
    logic [PTR_W-1:0]   grant_idx;
    logic               grant_any;
    logic               arb_en;
    logic [ADDR_W-1:0]  grant_addr;
    logic [DATA_W-1:0]  grant_data;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr_arbiter (
        .req       (req_valid),
        .ptr       (ptr_q),
        .grant     (grant),
        .grant_idx (grant_idx),
        .grant_any (grant_any)
    );

    assign grant_addr = req_addr[grant_idx*ADDR_W +: ADDR_W];
    assign grant_data = req_data[grant_idx*DATA_W +: DATA_W];

    // Arbitration runs in IDLE (unless a clear is starting, which takes priority) and in DONE.
    assign arb_en    = ((state_q == IDLE) && !clear_req) || (state_q == DONE);
    assign req_ready = (arb_en && !ctrl_reset) ? grant : '0;

    // FSM state register
    always_ff @(posedge clock) begin
        if (ctrl_reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (clear_req) state_d = CLEAR;
            CLEAR:   if (cnt_q == ADDR_W'(CLEAR_LAST)) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs and datapath next values
    always_comb begin
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        wr_en_d   = 1'b0;
        wr_addr_d = '0;
        wr_data_d = '0;
        if ((state_q == IDLE) && clear_req) begin
            cnt_d = ADDR_W'(CLEAR_FIRST);
        end
        if (state_q == CLEAR) begin
            wr_en_d   = 1'b1;
            wr_addr_d = cnt_q;
            if (cnt_q != ADDR_W'(CLEAR_LAST)) begin
                cnt_d = cnt_q + ADDR_W'(1);
            end
        end
        if (arb_en && grant_any) begin
            ptr_d = (int'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + PTR_W'(1);
`ifdef REGFILE_ARB_R0_DROP_EN
            // r0 writes are acknowledged but never reach the port, freeing the cycle.
            wr_en_d = (grant_addr != '0);
`else
            wr_en_d = 1'b1;
`endif
            wr_addr_d = wr_en_d ? grant_addr : '0;
            wr_data_d = wr_en_d ? grant_data : '0;
        end
    end

    always_ff @(posedge clock) begin
        if (ctrl_reset) begin
            ptr_q     <= '0;
            cnt_q     <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign clear_busy = (state_q == CLEAR);
    assign clear_done = (state_q == DONE);
    assign wr_en      = wr_en_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb/tb_regfile_write_arbiter.sv - scoreboard bench for regfile_write_arbiter
module tb_regfile_write_arbiter;

    localparam int N  = 4;
    localparam int AW = 5;
    localparam int DW = 32;

    logic            clock = 1'b0;
    logic            ctrl_reset;
    logic [N-1:0]    req_valid;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    req_ready;
    logic            clear_req;
    logic            clear_busy;
    logic            clear_done;
    logic            wr_en;
    logic [AW-1:0]   wr_addr;
    logic [DW-1:0]   wr_data;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wr_t;

    wr_t exp_q[$];
    wr_t exp_e;
    int  n_checks = 0;
    int  n_fail   = 0;

    regfile_write_arbiter #(.NUM_REQ(N), .DATA_W(DW), .ADDR_W(AW)) dut (
        .clock      (clock),
        .ctrl_reset (ctrl_reset),
        .req_valid  (req_valid),
        .req_addr   (req_addr),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .clear_req  (clear_req),
        .clear_busy (clear_busy),
        .clear_done (clear_done),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data)
    );

    always #5 clock = ~clock;

    // Write-port scoreboard: entries pushed in the grant cycle must appear exactly one cycle later.
    always begin
        @(posedge clock);
        #2;
        if (wr_en === 1'b1 || exp_q.size() > 0) begin
            n_checks++;
            if (wr_en !== 1'b1) begin
                n_fail++;
                $display("FAIL wr_missing: wr_en=%b required 1 for addr %0d", wr_en, exp_q[0].a);
                void'(exp_q.pop_front());
            end else if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL wr_unexpected: wr_en=1 addr=%0d data=%h, required no write", wr_addr, wr_data);
            end else begin
                exp_e = exp_q.pop_front();
                if (wr_addr !== exp_e.a || wr_data !== exp_e.d) begin
                    n_fail++;
                    $display("FAIL wr_payload: addr=%0d data=%h required addr=%0d data=%h",
                             wr_addr, wr_data, exp_e.a, exp_e.d);
                end
            end
        end
        n_checks++;
        if ((req_ready & ~req_valid) !== '0) begin
            n_fail++;
            $display("FAIL ready_without_valid: ready=%b valid=%b", req_ready, req_valid);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_addr[i*AW +: AW] = a;
        req_data[i*DW +: DW] = d;
    endtask

    task automatic pulse_reset();
        ctrl_reset = 1'b1;
        step();
        ctrl_reset = 1'b0;
    endtask

    task automatic test_reset();
        req_valid = 4'hF;
        @(negedge clock);
        n_checks++;
        if ({wr_en, wr_addr, wr_data, clear_busy, clear_done, req_ready} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: en=%b addr=%0d data=%h busy=%b done=%b ready=%b, required all 0",
                     wr_en, wr_addr, wr_data, clear_busy, clear_done, req_ready);
        end
        step();
        req_valid  = '0;
        ctrl_reset = 1'b0;
        step();
    endtask

    task automatic test_single();
        req_valid = 4'b0010;
        set_req(1, 5'd5, 32'hDEADBEEF);
        @(negedge clock);
        n_checks++;
        if (req_ready !== 4'b0010) begin
            n_fail++;
            $display("FAIL single_ready: ready=%b required 0010", req_ready);
        end
        exp_q.push_back('{a: 5'd5, d: 32'hDEADBEEF});
        step();
        req_valid = '0;
        @(negedge clock);
        n_checks++;
        if (wr_en !== 1'b1 || wr_addr !== 5'd5 || wr_data !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL single_write: en=%b addr=%0d data=%h required 1/5/deadbeef", wr_en, wr_addr, wr_data);
        end
        step();
    endtask

    task automatic test_round_robin();
        pulse_reset();
        for (int i = 0; i < N; i++) set_req(i, AW'(8 + i), 32'hA000_0000 + DW'(i));
        req_valid = 4'hF;
        for (int k = 0; k < 8; k++) begin
            @(negedge clock);
            n_checks++;
            if (req_ready !== 4'(1 << (k % 4))) begin
                n_fail++;
                $display("FAIL rr_order[%0d]: ready=%b required %b", k, req_ready, 4'(1 << (k % 4)));
            end
            exp_q.push_back('{a: AW'(8 + k % 4), d: 32'hA000_0000 + DW'(k % 4)});
            step();
        end
        req_valid = '0;
        step();
    endtask

    task automatic test_clear();
        req_valid = 4'b0001;
        set_req(0, 5'd3, 32'h0000_1234);
        clear_req = 1'b1;
        @(negedge clock);
        n_checks++;
        if (req_ready !== 4'b0000 || clear_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL clear_start: ready=%b busy=%b required 0000/0", req_ready, clear_busy);
        end
        step();
        clear_req = 1'b0;
        for (int k = 1; k <= 31; k++) begin
            @(negedge clock);
            n_checks++;
            if (req_ready !== 4'b0000 || clear_busy !== 1'b1 || clear_done !== 1'b0) begin
                n_fail++;
                $display("FAIL clear_cycle[%0d]: ready=%b busy=%b done=%b required 0000/1/0",
                         k, req_ready, clear_busy, clear_done);
            end
            exp_q.push_back('{a: AW'(k), d: '0});
            step();
            clear_req = (k == 4);
        end
        clear_req = 1'b0;
        @(negedge clock);
        n_checks++;
        if (clear_done !== 1'b1 || clear_busy !== 1'b0 || req_ready !== 4'b0001) begin
            n_fail++;
            $display("FAIL clear_done_cycle: done=%b busy=%b ready=%b required 1/0/0001",
                     clear_done, clear_busy, req_ready);
        end
        exp_q.push_back('{a: 5'd3, d: 32'h0000_1234});
        step();
        req_valid = '0;
        @(negedge clock);
        n_checks++;
        if (clear_done !== 1'b0) begin
            n_fail++;
            $display("FAIL clear_done_pulse: done=%b required 0", clear_done);
        end
        step();
    endtask

    task automatic test_reset_mid_clear();
        clear_req = 1'b1;
        step();
        clear_req = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clock);
            exp_q.push_back('{a: AW'(k), d: '0});
            step();
        end
        ctrl_reset = 1'b1;
        step();
        ctrl_reset = 1'b0;
        @(negedge clock);
        n_checks++;
        if ({wr_en, wr_addr, wr_data, clear_busy, clear_done} !== '0) begin
            n_fail++;
            $display("FAIL abort_outputs: en=%b addr=%0d data=%h busy=%b done=%b required all 0",
                     wr_en, wr_addr, wr_data, clear_busy, clear_done);
        end
        for (int k = 0; k < 40; k++) begin
            step();
            @(negedge clock);
            n_checks++;
            if (clear_done !== 1'b0 || clear_busy !== 1'b0 || wr_en !== 1'b0) begin
                n_fail++;
                $display("FAIL abort_quiet[%0d]: done=%b busy=%b en=%b required 0/0/0",
                         k, clear_done, clear_busy, wr_en);
            end
        end
        step();
    endtask

    task automatic test_r0();
        req_valid = 4'b0100;
        set_req(2, 5'd0, 32'd7);
        @(negedge clock);
        n_checks++;
        if (req_ready !== 4'b0100) begin
            n_fail++;
            $display("FAIL r0_ready: ready=%b required 0100", req_ready);
        end
`ifndef REGFILE_ARB_R0_DROP_EN
        exp_q.push_back('{a: 5'd0, d: 32'd7});
`endif
        step();
        req_valid = '0;
        @(negedge clock);
        n_checks++;
`ifdef REGFILE_ARB_R0_DROP_EN
        if (wr_en !== 1'b0) begin
            n_fail++;
            $display("FAIL r0_drop: wr_en=%b required 0", wr_en);
        end
`else
        if (wr_en !== 1'b1 || wr_addr !== 5'd0) begin
            n_fail++;
            $display("FAIL r0_forward: en=%b addr=%0d required 1/0", wr_en, wr_addr);
        end
`endif
        step();
    endtask

    task automatic test_hold();
        pulse_reset();
        set_req(3, 5'd20, 32'hCAFE_0003);
        set_req(1, 5'd21, 32'h11);
        req_valid = 4'b1010;
        @(negedge clock);
        n_checks++;
        if (req_ready !== 4'b0010) begin
            n_fail++;
            $display("FAIL hold_a: ready=%b required 0010", req_ready);
        end
        exp_q.push_back('{a: 5'd21, d: 32'h11});
        step();
        set_req(2, 5'd22, 32'h22);
        req_valid = 4'b1100;
        @(negedge clock);
        n_checks++;
        if (req_ready !== 4'b0100) begin
            n_fail++;
            $display("FAIL hold_b: ready=%b required 0100", req_ready);
        end
        exp_q.push_back('{a: 5'd22, d: 32'h22});
        step();
        set_req(0, 5'd23, 32'h33);
        req_valid = 4'b1001;
        @(negedge clock);
        n_checks++;
        if (req_ready !== 4'b1000) begin
            n_fail++;
            $display("FAIL hold_c: ready=%b required 1000", req_ready);
        end
        exp_q.push_back('{a: 5'd20, d: 32'hCAFE_0003});
        step();
        req_valid = 4'b0001;
        @(negedge clock);
        n_checks++;
        if (req_ready !== 4'b0001) begin
            n_fail++;
            $display("FAIL hold_ptr_wrap: ready=%b required 0001", req_ready);
        end
        exp_q.push_back('{a: 5'd23, d: 32'h33});
        step();
        req_valid = '0;
        repeat (3) step();
    endtask

    initial begin
        ctrl_reset = 1'b1;
        req_valid  = '0;
        req_addr   = '0;
        req_data   = '0;
        clear_req  = 1'b0;
        step();
        test_reset();
        test_single();
        test_round_robin();
        test_clear();
        test_reset_mid_clear();
        test_r0();
        test_hold();
        repeat (2) step();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
